// File: rtl/prediction_argmax_if.sv
// prediction_argmax_if: score stream in, argmax result stream out.
// master = score producer / result consumer, slave = argmax block.
interface prediction_argmax_if #(
    parameter int N_CLASSES = 10,
    parameter int DATA_W    = 16
);
    localparam int LABEL_W =
        ($clog2(N_CLASSES) < 1) ? 1 : $clog2(N_CLASSES);

    logic [DATA_W-1:0]  score_in;
    logic               score_in_valid;
    logic               score_in_ready;
    logic [LABEL_W-1:0] label_in;
    logic [LABEL_W-1:0] result_class;
    logic [DATA_W-1:0]  result_score;
    logic               result_correct;
    logic               result_valid;
    logic               result_ready;

    modport master (
        output score_in,
        output score_in_valid,
        output label_in,
        output result_ready,
        input  score_in_ready,
        input  result_class,
        input  result_score,
        input  result_correct,
        input  result_valid
    );

    modport slave (
        input  score_in,
        input  score_in_valid,
        input  label_in,
        input  result_ready,
        output score_in_ready,
        output result_class,
        output result_score,
        output result_correct,
        output result_valid
    );
endinterface

// File: rtl/prediction_argmax.sv
// prediction_argmax: per-frame argmax over N_CLASSES score beats,
// label match flag and saturating frame/mispredict statistics.
// Ports: clock, reset_n (async, active low), flush (drop partial
// frame), clear_stats, sif (score stream in / result out),
// total_count, mispred_count.
module prediction_argmax #(
    parameter int N_CLASSES = 10,
    parameter int DATA_W    = 16,
    parameter int SIGNED    = 1,
    parameter int CNT_W     = 16,
    localparam int LABEL_W  =
        ($clog2(N_CLASSES) < 1) ? 1 : $clog2(N_CLASSES)
) (
    input  logic               clock,
    input  logic               reset_n,
    input  logic               flush,
    input  logic               clear_stats,
    prediction_argmax_if.slave sif,
    output logic [CNT_W-1:0]   total_count,
    output logic [CNT_W-1:0]   mispred_count
);

    typedef enum logic {
        ACCUM = 1'b0,
        HOLD  = 1'b1
    } state_t;

    localparam logic [LABEL_W-1:0] LAST =
        LABEL_W'(N_CLASSES - 1);
    localparam logic [LABEL_W:0] N_LIM =
        (LABEL_W+1)'(N_CLASSES);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    state_t             state;
    logic [LABEL_W-1:0] beat_cnt;
    logic [LABEL_W-1:0] best_idx;
    logic [LABEL_W-1:0] label_q;
    logic [DATA_W-1:0]  best_score;
    logic               correct_q;
    logic               ready_q;
    logic               valid_q;

    logic               accept;
    logic               first;
    logic               last;
    logic               greater;
    logic               take;
    logic [LABEL_W-1:0] nxt_idx;
    logic               label_ok;
    logic               fin_correct;
    logic               frame_done;

    // ready_q is only 1 in ACCUM, so it also qualifies the state
    assign accept = ready_q && sif.score_in_valid && !flush;
    assign first  = (beat_cnt == '0);
    assign last   = (beat_cnt == LAST);

    always_comb begin
        greater = 1'b0;
        if (SIGNED != 0)
            greater = $signed(sif.score_in) > $signed(best_score);
        else
            greater = sif.score_in > best_score;
    end

    // strict compare keeps the lower index on ties
    assign take    = first || greater;
    assign nxt_idx = take ? beat_cnt : best_idx;

    // labels outside the class range can never match
    assign label_ok    = {1'b0, label_q} < N_LIM;
    assign fin_correct = label_ok && (nxt_idx == label_q);
    assign frame_done  = accept && last;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state      <= ACCUM;
            beat_cnt   <= '0;
            best_idx   <= '0;
            best_score <= '0;
            label_q    <= '0;
            correct_q  <= 1'b0;
            ready_q    <= 1'b0;
            valid_q    <= 1'b0;
        end else begin
            unique case (state)
                ACCUM: begin
                    ready_q <= 1'b1;
                    if (flush) begin
                        beat_cnt <= '0;
                    end else if (accept) begin
                        if (take) begin
                            best_score <= sif.score_in;
                            best_idx   <= beat_cnt;
                        end
                        if (first)
                            label_q <= sif.label_in;
                        if (last) begin
                            beat_cnt  <= '0;
                            state     <= HOLD;
                            ready_q   <= 1'b0;
                            valid_q   <= 1'b1;
                            correct_q <= fin_correct;
                        end else begin
                            beat_cnt <= beat_cnt + 1'b1;
                        end
                    end
                end
                HOLD: begin
                    if (valid_q && sif.result_ready) begin
                        state   <= ACCUM;
                        valid_q <= 1'b0;
                        ready_q <= 1'b1;
                    end
                end
                default: begin
                    state   <= ACCUM;
                    valid_q <= 1'b0;
                    ready_q <= 1'b0;
                end
            endcase
        end
    end

    // statistics: clear has priority over a frame completing
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            total_count   <= '0;
            mispred_count <= '0;
        end else if (clear_stats) begin
            total_count   <= '0;
            mispred_count <= '0;
        end else if (frame_done) begin
            if (total_count != CNT_MAX)
                total_count <= total_count + 1'b1;
            if (!fin_correct && mispred_count != CNT_MAX)
                mispred_count <= mispred_count + 1'b1;
        end
    end

    assign sif.score_in_ready = ready_q;
    assign sif.result_valid   = valid_q;
    assign sif.result_class   = best_idx;
    assign sif.result_score   = best_score;
    assign sif.result_correct = correct_q;

endmodule

// File: tb/tb_prediction_argmax.sv
// tb_prediction_argmax: random and directed frames against a
// queue-based argmax model, checked every cycle on three configs.
module tb_prediction_argmax;
    localparam int N  = 10;
    localparam int DW = 16;

    logic clock = 1'b0;
    logic reset_n = 1'b0;
    logic flush = 1'b0;
    logic clear_stats = 1'b0;

    always #5 clock = ~clock;

    prediction_argmax_if #(.N_CLASSES(N), .DATA_W(DW)) bus ();
    prediction_argmax_if #(.N_CLASSES(N), .DATA_W(DW)) bus_u ();
    prediction_argmax_if #(.N_CLASSES(N), .DATA_W(DW)) bus_s ();

    assign bus_u.score_in       = bus.score_in;
    assign bus_u.score_in_valid = bus.score_in_valid;
    assign bus_u.label_in       = bus.label_in;
    assign bus_u.result_ready   = bus.result_ready;
    assign bus_s.score_in       = bus.score_in;
    assign bus_s.score_in_valid = bus.score_in_valid;
    assign bus_s.label_in       = bus.label_in;
    assign bus_s.result_ready   = bus.result_ready;

    logic [15:0] tot, mis, tot_u, mis_u;
    logic [1:0]  tot_s, mis_s;

    prediction_argmax #(.N_CLASSES(N), .DATA_W(DW),
                        .SIGNED(1), .CNT_W(16)) dut (
        .clock(clock), .reset_n(reset_n), .flush(flush),
        .clear_stats(clear_stats), .sif(bus.slave),
        .total_count(tot), .mispred_count(mis));

    prediction_argmax #(.N_CLASSES(N), .DATA_W(DW),
                        .SIGNED(0), .CNT_W(16)) dut_u (
        .clock(clock), .reset_n(reset_n), .flush(flush),
        .clear_stats(clear_stats), .sif(bus_u.slave),
        .total_count(tot_u), .mispred_count(mis_u));

    prediction_argmax #(.N_CLASSES(N), .DATA_W(DW),
                        .SIGNED(1), .CNT_W(2)) dut_s (
        .clock(clock), .reset_n(reset_n), .flush(flush),
        .clear_stats(clear_stats), .sif(bus_s.slave),
        .total_count(tot_s), .mispred_count(mis_s));

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic timeout(input string nm);
        n_chk++;
        n_err++;
        $display("FAIL %s: timeout waiting for DUT", nm);
    endtask

    // ---------------- behavioural model ----------------
    bit          started, holding;
    logic [15:0] fr[$];
    int          lbl;
    int          e_cls, e_cls_u;
    logic [15:0] e_sc, e_sc_u;
    bit          e_cor, e_cor_u;
    int          e_tot, e_mis, e_mis_u, e_tot_s, e_mis_s;

    function automatic longint val(input logic [15:0] x,
                                   input bit sgn);
        if (sgn) return longint'($signed(x));
        return longint'({48'd0, x});
    endfunction

    function automatic int argmax(input logic [15:0] f[$],
                                  input bit sgn);
        int idx = 0;
        for (int i = 1; i < f.size(); i++)
            if (val(f[i], sgn) > val(f[idx], sgn)) idx = i;
        return idx;
    endfunction

    function automatic int sat(input int v, input int mx);
        return (v > mx) ? mx : v;
    endfunction

    task automatic model_reset();
        started = 0; holding = 0; fr.delete(); lbl = 0;
        e_cls = 0; e_cls_u = 0; e_sc = 0; e_sc_u = 0;
        e_cor = 0; e_cor_u = 0;
        e_tot = 0; e_mis = 0; e_mis_u = 0;
        e_tot_s = 0; e_mis_s = 0;
    endtask

    task automatic finish_frame();
        e_cls   = argmax(fr, 1'b1);
        e_sc    = fr[e_cls];
        e_cor   = (lbl < N) && (e_cls == lbl);
        e_cls_u = argmax(fr, 1'b0);
        e_sc_u  = fr[e_cls_u];
        e_cor_u = (lbl < N) && (e_cls_u == lbl);
        e_tot   = sat(e_tot + 1, 65535);
        e_tot_s = sat(e_tot_s + 1, 3);
        if (!e_cor) begin
            e_mis   = sat(e_mis + 1, 65535);
            e_mis_s = sat(e_mis_s + 1, 3);
        end
        if (!e_cor_u) e_mis_u = sat(e_mis_u + 1, 65535);
    endtask

    initial begin
        model_reset();
        forever begin
            @(posedge clock or negedge reset_n);
            if (!reset_n) begin
                model_reset();
            end else begin
                if (holding) begin
                    if (bus.result_ready) holding = 0;
                end else if (started) begin
                    if (flush) begin
                        fr.delete();
                    end else if (bus.score_in_valid) begin
                        if (fr.size() == 0) lbl = int'(bus.label_in);
                        fr.push_back(bus.score_in);
                        if (fr.size() == N) begin
                            finish_frame();
                            fr.delete();
                            holding = 1;
                        end
                    end
                end
                started = 1;
                if (clear_stats) begin
                    e_tot = 0; e_mis = 0; e_mis_u = 0;
                    e_tot_s = 0; e_mis_s = 0;
                end
            end
        end
    end

    // ---------------- per-cycle compare ----------------
    initial begin
        forever begin
            @(negedge clock);
            chk("ready", bus.score_in_ready, started && !holding);
            chk("valid", bus.result_valid, holding);
            chk("valid_u", bus_u.result_valid, holding);
            chk("valid_s", bus_s.result_valid, holding);
            chk("total", tot, e_tot);
            chk("mispred", mis, e_mis);
            chk("total_u", tot_u, e_tot);
            chk("mispred_u", mis_u, e_mis_u);
            chk("total_s", tot_s, e_tot_s);
            chk("mispred_s", mis_s, e_mis_s);
            if (holding || !started) begin
                chk("class", bus.result_class, e_cls);
                chk("score", bus.result_score, e_sc);
                chk("correct", bus.result_correct, e_cor);
                chk("class_u", bus_u.result_class, e_cls_u);
                chk("score_u", bus_u.result_score, e_sc_u);
                chk("correct_u", bus_u.result_correct, e_cor_u);
            end
        end
    end

    // ---------------- stimulus ----------------
    typedef logic [15:0] frame_t [N];

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic send_beat(input logic [15:0] s,
                             input int l, input bit clr);
        int guard = 0;
        bus.score_in       = s;
        bus.label_in       = 4'(l);
        bus.score_in_valid = 1'b1;
        while (!bus.score_in_ready && guard < 60) begin
            step();
            guard++;
        end
        if (guard >= 60) timeout("beat_accept");
        clear_stats = clr;
        step();
        clear_stats = 1'b0;
        bus.score_in_valid = 1'b0;
    endtask

    task automatic send_frame(input frame_t f, input int l,
                              input int gapmax, input bit clr);
        for (int i = 0; i < N; i++) begin
            repeat ($urandom_range(0, gapmax)) step();
            send_beat(f[i], l, clr && (i == N - 1));
        end
    endtask

    task automatic wait_valid();
        int guard = 0;
        while (!bus.result_valid && guard < 40) begin
            step();
            guard++;
        end
        if (guard >= 40) timeout("result_valid");
    endtask

    task automatic release_result();
        bus.result_ready = 1'b1;
        step();
        bus.result_ready = 1'b0;
    endtask

    frame_t      f;
    logic [3:0]  hold_cls;
    logic [15:0] tot_before;

    initial begin
        bus.score_in = '0;
        bus.score_in_valid = 1'b0;
        bus.label_in = '0;
        bus.result_ready = 1'b0;
        repeat (3) step();
        chk("rst_ready", bus.score_in_ready, 0);
        chk("rst_class", bus.result_class, 0);
        reset_n = 1'b1;
        chk("ready_pre_edge", bus.score_in_ready, 0);
        step();
        chk("ready_post_edge", bus.score_in_ready, 1);

        f = '{16'h0010, 16'h0200, 16'h0100, 16'h0020, 16'h0030,
              16'h0040, 16'h0050, 16'h0060, 16'h0070, 16'h0080};
        send_frame(f, 1, 0, 0);
        chk("lat1_valid", bus.result_valid, 1);
        chk("f1_class", bus.result_class, 1);
        chk("f1_score", bus.result_score, 16'h0200);
        chk("f1_correct", bus.result_correct, 1);
        chk("f1_total", tot, 1);
        chk("f1_mis", mis, 0);
        release_result();

        f = '{16'hF000, 16'hF100, 16'hF200, 16'hF300, 16'hF400,
              16'hF500, 16'hF600, 16'hFF80, 16'hFF00, 16'h8000};
        send_frame(f, 3, 2, 0);
        wait_valid();
        chk("neg_class", bus.result_class, 7);
        chk("neg_correct", bus.result_correct, 0);
        chk("neg_mis", mis, 1);
        chk("neg_class_u", bus_u.result_class, 7);
        release_result();

        f = '{16'h7FFF, 16'h0001, 16'h0002, 16'h8000, 16'h0003,
              16'h0004, 16'h0005, 16'h0006, 16'h0007, 16'h0008};
        send_frame(f, 0, 1, 0);
        wait_valid();
        chk("mix_class", bus.result_class, 0);
        chk("mix_class_u", bus_u.result_class, 3);
        chk("mix_correct_u", bus_u.result_correct, 0);
        release_result();

        f = '{16'h0010, 16'h0010, 16'h0100, 16'h0010, 16'h0010,
              16'h0100, 16'h0010, 16'h0010, 16'h0010, 16'h0010};
        send_frame(f, 2, 0, 0);
        wait_valid();
        chk("tie_class", bus.result_class, 2);
        chk("tie_correct", bus.result_correct, 1);
        hold_cls = bus.result_class;

        bus.score_in = 16'h7000;
        bus.score_in_valid = 1'b1;
        repeat (20) step();
        chk("stall_class", bus.result_class, hold_cls);
        chk("stall_ready", bus.score_in_ready, 0);
        chk("stall_valid", bus.result_valid, 1);
        release_result();
        chk("exit_valid", bus.result_valid, 0);
        chk("exit_ready", bus.score_in_ready, 1);
        bus.score_in_valid = 1'b0;

        tot_before = tot;
        for (int i = 0; i < 4; i++) send_beat(16'h7F00, 0, 0);
        flush = 1'b1;
        bus.score_in_valid = 1'b1;
        step();
        flush = 1'b0;
        bus.score_in_valid = 1'b0;
        f = '{16'h0001, 16'h0002, 16'h0003, 16'h0004, 16'h0005,
              16'h0900, 16'h0006, 16'h0007, 16'h0008, 16'h0009};
        send_frame(f, 5, 1, 0);
        wait_valid();
        chk("flush_class", bus.result_class, 5);
        chk("flush_score", bus.result_score, 16'h0900);
        chk("flush_total", tot, tot_before + 16'd1);
        chk("sat_total", tot_s, 3);
        release_result();

        send_frame(f, 9, 0, 1);
        chk("clr_total", tot, 0);
        chk("clr_mis", mis, 0);
        chk("clr_total_s", tot_s, 0);
        release_result();

        for (int k = 0; k < 40; k++) begin
            for (int i = 0; i < N; i++) begin
                if (k % 2 == 0) begin
                    case ($urandom_range(0, 4))
                        0: f[i] = 16'h0000;
                        1: f[i] = 16'h0100;
                        2: f[i] = 16'hFF00;
                        3: f[i] = 16'h7FFF;
                        default: f[i] = 16'h8000;
                    endcase
                end else begin
                    f[i] = 16'($urandom);
                end
            end
            if ($urandom_range(0, 5) == 0) begin
                for (int i = 0; i < $urandom_range(1, N - 1); i++)
                    send_beat(f[i], 3, 0);
                flush = 1'b1;
                bus.score_in_valid = 1'($urandom_range(0, 1));
                step();
                flush = 1'b0;
                bus.score_in_valid = 1'b0;
            end
            send_frame(f, $urandom_range(0, 15), 2,
                       $urandom_range(0, 7) == 0);
            wait_valid();
            repeat ($urandom_range(0, 3)) step();
            release_result();
        end

        for (int i = 0; i < 5; i++) send_beat(16'h0100, 1, 0);
        reset_n = 1'b0;
        step();
        chk("rst_mid_total", tot, 0);
        reset_n = 1'b1;
        step();
        send_frame(f, 4, 0, 0);
        wait_valid();
        chk("post_rst_total", tot, 1);
        release_result();
        repeat (3) step();

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/prediction_argmax.md
PREDICTION_ARGMAX -- requirements
Module: prediction_argmax

Interface
REQ-001 Parameter N_CLASSES, default 10: score beats per frame; legal range 2..256.
REQ-002 Parameter DATA_W, default 16: score width (8.8 fixed point at default).
REQ-003 Parameter SIGNED, default 1: 1 = two's-complement compare, 0 = unsigned compare.
REQ-004 Parameter CNT_W, default 16: width of the statistics counters.
REQ-005 Localparam LABEL_W = max(1, $clog2(N_CLASSES)).
REQ-006 clock  in  1  sole clock; all state updates on the rising edge.
REQ-007 reset_n  in  1  asynchronous, active-low reset.
REQ-008 score_in  in  DATA_W  class score beat, class index = beat order.
REQ-009 score_in_valid  in  1  score beat valid.
REQ-010 score_in_ready  out  1  block accepts a score beat.
REQ-011 label_in  in  LABEL_W  expected class, sampled with beat 0 only.
REQ-012 flush  in  1  synchronous abort of a partial frame.
REQ-013 result_class  out  LABEL_W  index of the maximum score.
REQ-014 result_score  out  DATA_W  maximum score value.
REQ-015 result_correct  out  1  result_class equals the sampled label.
REQ-016 result_valid  out  1  result fields valid.
REQ-017 result_ready  in  1  consumer accepts the result.
REQ-018 clear_stats  in  1  synchronous clear of both counters.
REQ-019 total_count  out  CNT_W  completed frames since the last clear.
REQ-020 mispred_count  out  CNT_W  frames with result_correct = 0.

Function
REQ-021 FSM shall have two states, ACCUM and HOLD; score_in_ready = (state == ACCUM); result_valid = (state == HOLD).
REQ-022 A beat is accepted when score_in_valid && score_in_ready; the beat index counter (0..N_CLASSES-1) increments per accepted beat.
REQ-023 Beat 0 shall load best_score/best_idx unconditionally and register label_in.
REQ-024 Beat k>0 shall replace best only if score_in is strictly greater than best_score (signedness per SIGNED); ties keep the lower index.
REQ-025 Acceptance of beat N_CLASSES-1 shall move the FSM to HOLD; result_valid rises on the next edge (latency 1 cycle after the last beat); the beat counter wraps to 0.
REQ-026 The final-beat compare shall be included in result_class/result_score; outputs come directly from registers.
REQ-027 result_correct = (best_idx == stored label); a label >= N_CLASSES shall always yield result_correct = 0.
REQ-028 In HOLD, result fields shall stay stable until result_valid && result_ready, then the FSM returns to ACCUM on the same edge.
REQ-029 A new frame shall not be accepted in the HOLD-exit cycle (score_in_ready is 0 in that cycle).
REQ-030 On the edge entering HOLD, total_count shall increment, and mispred_count shall increment when the frame is incorrect.
REQ-031 Both counters shall saturate at 2^CNT_W-1.
REQ-032 clear_stats shall zero both counters; it wins over a simultaneous increment.
REQ-033 flush in ACCUM shall reset the beat counter to 0 and discard partial state; a beat offered in the same cycle is dropped and counters are unchanged.
REQ-034 flush in HOLD shall be ignored.
REQ-035 With valid gaps between beats, state shall hold; there is no timeout.

Reset
REQ-036 While reset_n = 0: state = ACCUM, beat counter = 0, best_score = 0, best_idx = 0, label = 0, result_* = 0, result_valid = 0, score_in_ready = 0, counters = 0.
REQ-037 score_in_ready shall go to 1 on the first edge after reset_n deasserts.
REQ-038 Reset asserted mid-frame or in HOLD shall discard the frame without counting it.

Verification
REQ-039 Scores 0x0010,0x0200,0x0100,...(10 beats, max at index 1), label 1 -> result_class 1, result_score 0x0200, correct = 1, total_count 1, mispred_count 0.
REQ-040 SIGNED = 1, all scores negative, max 0xFF80 at index 7, label 3 -> result_class 7, correct = 0, mispred_count 1; with SIGNED = 0 the same data yields the index of the largest unsigned value.
REQ-041 Equal 0x0100 at indices 2 and 5 (maximum) -> result_class 2.
REQ-042 result_ready held 0 for 20 cycles with score_in_valid = 1 -> no beat accepted, result stable; one-cycle ready -> FSM returns to ACCUM, next frame starts one cycle later.
REQ-043 flush after 4 beats, then a full 10-beat frame -> the result reflects only the new frame; total_count increments once.
REQ-044 CNT_W = 2, 5 frames -> total_count saturates at 3; clear_stats coincident with a frame end -> counters read 0.
